// File: rtl/bias_loader.sv
// ============================================================================
// Module   : bias_loader
// Purpose  : Run-time loader for the per-layer CNN bias table. Accepts
//            N_CH*N_LAYER bias words over a valid/ready stream after a start
//            pulse, then drives the selected layer's biases as one
//            registered wide bus.
// Options  : define BIAS_CHECKSUM_EN to add a 16-bit running checksum output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// Word width and layer codes normally come from num_data.v and
// state_layer_data.v; these fallbacks apply only when those are absent.
`ifndef DATA_LEN
`define DATA_LEN 16
`endif
`ifndef LAYER0
`define LAYER0 4'd0
`endif
`ifndef LAYER1
`define LAYER1 4'd1
`endif
`ifndef LAYER2
`define LAYER2 4'd2
`endif
`ifndef LAYER3
`define LAYER3 4'd3
`endif
`ifndef AFFINE
`define AFFINE 4'd4
`endif

module bias_loader #(
  parameter int N_CH    = 32,
  parameter int N_LAYER = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [`DATA_LEN-1:0]        in_data,
  input  logic [3:0]                  cs_layer,
  output logic [N_CH*`DATA_LEN-1:0]   bias_out,
  output logic                        busy,
  output logic                        done,
`ifdef BIAS_CHECKSUM_EN
  output logic [15:0]                 checksum,
`endif
  output logic                        loaded
);

  localparam int W      = `DATA_LEN;
  localparam int DEPTH  = N_CH * N_LAYER;
  localparam int ADDR_W = 8;
  localparam int LIDX_W = 3;
  localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                in_ready_q;
  logic                busy_q;
  logic                done_q;
  logic                loaded_q;
  logic [N_CH*W-1:0]   bias_out_q;
  logic [W-1:0]        mem_q [DEPTH];

  logic                w_acc;
  logic                w_layer_vld;
  logic [LIDX_W-1:0]   w_layer_idx;
  logic [ADDR_W-1:0]   w_rd_base;

  // in_ready is only ever high in LOAD, so it alone qualifies acceptance.
  assign w_acc = in_valid & in_ready_q;

  // Control FSM with registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      loaded_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q    <= S_LOAD;
            addr_q     <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            loaded_q   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_acc) begin
            addr_q <= addr_q + 1'b1;
            if (addr_q == C_LAST) begin
              state_q    <= S_DONE;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              loaded_q   <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  // Bias table write port; storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_acc) mem_q[addr_q] <= in_data;
  end

  // Decode the layer code into a table row; unknown codes flag as invalid.
  always_comb begin
    w_layer_vld = 1'b1;
    w_layer_idx = '0;
    case (cs_layer)
      `LAYER0: w_layer_idx = LIDX_W'(0);
      `LAYER1: w_layer_idx = LIDX_W'(1);
      `LAYER2: w_layer_idx = LIDX_W'(2);
      `LAYER3: w_layer_idx = LIDX_W'(3);
      `AFFINE: w_layer_idx = LIDX_W'(4);
      default: w_layer_vld = 1'b0;
    endcase
    w_rd_base = ADDR_W'(32'(w_layer_idx) * N_CH);
  end

  // Registered read of the selected row; a same-edge write is seen next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bias_out_q <= '0;
    end else if (w_layer_vld) begin
      for (int i = 0; i < N_CH; i++) begin
        bias_out_q[i*W +: W] <= mem_q[w_rd_base + ADDR_W'(i)];
      end
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign loaded   = loaded_q;
  assign bias_out = bias_out_q;

`ifdef BIAS_CHECKSUM_EN
  logic [15:0] csum_q;
  logic [15:0] csum_d;

  // Running sum of accepted words, restarted on each new load.
  always_comb begin
    csum_d = csum_q;
    if (state_q == S_IDLE && start) csum_d = '0;
    else if (w_acc)                 csum_d = csum_q + 16'(in_data);
  end

  // Checksum accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  assign checksum = csum_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bias_loader.sv
// ============================================================================
// Module   : tb_bias_loader
// Purpose  : Directed self-checking bench for bias_loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DATA_LEN
`define DATA_LEN 16
`endif
`ifndef LAYER0
`define LAYER0 4'd0
`endif
`ifndef LAYER1
`define LAYER1 4'd1
`endif
`ifndef LAYER2
`define LAYER2 4'd2
`endif
`ifndef LAYER3
`define LAYER3 4'd3
`endif
`ifndef AFFINE
`define AFFINE 4'd4
`endif

module tb_bias_loader;

  localparam int W    = `DATA_LEN;
  localparam int N_CH = 32;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                start = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [W-1:0]        in_data = '0;
  logic [3:0]          cs_layer = `LAYER0;
  logic [N_CH*W-1:0]   bias_out;
  logic                busy;
  logic                done;
  logic                loaded;
`ifdef BIAS_CHECKSUM_EN
  logic [15:0]         checksum;
`endif

  int n_vec = 0;
  int n_err = 0;

  bias_loader #(.N_CH(N_CH), .N_LAYER(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .cs_layer (cs_layer),
    .bias_out (bias_out),
    .busy     (busy),
    .done     (done),
`ifdef BIAS_CHECKSUM_EN
    .checksum (checksum),
`endif
    .loaded   (loaded)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] chan(input int i);
    return 32'(bias_out[i*W +: W]);
  endfunction

  // Select a layer, wait one edge, compare every channel to base+i.
  task automatic chk_layer(input string tag, input logic [3:0] code, input int base);
    cs_layer = code;
    tick();
    for (int i = 0; i < N_CH; i++) chk($sformatf("%s_ch%0d", tag, i), chan(i), 32'(base + i));
  endtask

  task automatic start_load();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_ready", 32'(in_ready), 1);
    chk("start_busy", 32'(busy), 1);
    chk("start_loaded", 32'(loaded), 0);
  endtask

  // Stream words first..last with data base+k; word 160 completes the load.
  task automatic load_words(input int first, input int last, input int base, input bit gap);
    for (int k = first; k <= last; k++) begin
      if (gap) begin
        in_valid = 1'b0;
        tick();
        chk("gap_done", 32'(done), 0);
        chk("gap_ready", 32'(in_ready), 1);
      end
      in_valid = 1'b1;
      in_data  = W'(base + k);
      tick();
      if (k == 160) begin
        in_valid = 1'b0;
        chk("last_done", 32'(done), 1);
        chk("last_loaded", 32'(loaded), 1);
        chk("last_busy", 32'(busy), 0);
        chk("last_ready", 32'(in_ready), 0);
        // start in the DONE cycle must be ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("post_done", 32'(done), 0);
        chk("post_loaded", 32'(loaded), 1);
        chk("post_ready", 32'(in_ready), 0);
        tick();
        chk("idle_ready", 32'(in_ready), 0);
        chk("idle_busy", 32'(busy), 0);
      end else begin
        chk("load_ready", 32'(in_ready), 1);
        chk("load_done", 32'(done), 0);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    // 1. Reset
    rst_n = 1'b0;
    #1;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_loaded", 32'(loaded), 0);
    chk("rst_bias_zero", 32'(|bias_out), 0);
    rst_n = 1'b1;
    tick();

    // 2. Full load with continuous valid, data 1..160
    start_load();
    load_words(1, 160, 0, 1'b0);
    chk_layer("l1_a", `LAYER1, 33);
    chk_layer("aff_a", `AFFINE, 129);

    // 4a. start pulse mid-load is ignored; address continues
    start_load();
    load_words(1, 30, 1000, 1'b0);
    in_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_start_ready", 32'(in_ready), 1);
    chk("ign_start_busy", 32'(busy), 1);
    load_words(31, 160, 1000, 1'b0);
    chk_layer("l0_b", `LAYER0, 1001);
    chk_layer("l2_b", `LAYER2, 1065);

    // 4b. Reset after 50 words aborts; written entries survive
    start_load();
    load_words(1, 50, 2000, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(in_ready), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_loaded", 32'(loaded), 0);
    chk("abort_bias_zero", 32'(|bias_out), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("abort_idle_ready", 32'(in_ready), 0);
    chk_layer("l0_kept", `LAYER0, 2001);
    chk_layer("l2_kept", `LAYER2, 1065);

    // 3. Fresh gapped load, data 1..160
    start_load();
    load_words(1, 160, 0, 1'b1);
    chk_layer("l0_c", `LAYER0, 1);
    chk_layer("l3_c", `LAYER3, 97);
    chk_layer("aff_c", `AFFINE, 129);

    // 5. Invalid layer code holds the previous bus
    chk_layer("l2_d", `LAYER2, 65);
    chk_layer("inv_hold", 4'hF, 65);
    chk_layer("inv_hold2", 4'hF, 65);

`ifdef BIAS_CHECKSUM_EN
    // 6. Checksum over 160 words of 1000
    start_load();
    chk("cs_clear", 32'(checksum), 0);
    for (int k = 1; k <= 160; k++) begin
      in_valid = 1'b1;
      in_data  = W'(1000);
      tick();
    end
    in_valid = 1'b0;
    chk("cs_done", 32'(done), 1);
    chk("cs_value", 32'(checksum), 28928);
    tick();
    chk("cs_stable", 32'(checksum), 28928);
    start_load();
    chk("cs_restart", 32'(checksum), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
